cdb_result_buffer: RTL and testbench
====================================

Name: cdb_result_buffer

Overview:
- Requester-side endpoint of the result-bus arbitration protocol in the OoO pipeline.
- One instance sits between each functional unit (ALU or load/store) and the result-bus arbiter.
- Queues completed results, drives the unit's request line (is_alu / is_ls) and honours the arbiter's stall (stall_alu / stall_ls).
- Drives the granted result onto the common data bus and back-pressures the functional unit when full.

Parameters:
- DEPTH, 4, number of result entries; power of two, at least 2.
- DATA_W, 32, result data width.
- TAG_W, 6, ROB/physical-register tag width.
- CNT_W, 8, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squash all buffered results (mispredict/exception).
- in_valid  in  1  functional unit presents a completed result.
- in_tag  in  TAG_W  destination tag of the incoming result.
- in_data  in  DATA_W  incoming result value.
- in_ready  out  1  buffer can accept a result this cycle.
- req  out  1  request to arbiter; connects to is_alu or is_ls.
- stall  in  1  arbiter refusal; connects to stall_alu or stall_ls; combinational from req in the same cycle.
- cdb_valid  out  1  result on the bus is granted this cycle.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_data  out  DATA_W  broadcast value.
- stall_cycles  out  CNT_W  count of cycles with req=1 and stall=1; saturating.

Behaviour:
- Storage:
  - Circular FIFO with head pointer, tail pointer and count, each log2(DEPTH)+1 bits wide.
  - Pointers wrap modulo DEPTH.
- Reset (rst=1 at posedge):
  - count=0, head=tail=0, stall_cycles=0.
  - Outputs after reset: req=0, cdb_valid=0, in_ready=1, cdb_tag=0, cdb_data=0.
  - Reset overrides flush and every other input, including mid-operation.
- Flush (flush=1, rst=0):
  - At posedge, count=0 and head=tail.
  - in_valid in the flush cycle is dropped.
  - req, cdb_valid and grant are forced 0 during the flush cycle; no pop occurs.
  - stall_cycles is not cleared.
- Push: when in_valid && in_ready, the entry is written at tail on posedge and tail increments.
- Ready: in_ready = (count < DEPTH). No same-cycle pass-through on full, so there is no stall-to-in_ready combinational path.
- Request: req = (count != 0) && !flush. It is combinational from registered count, so the registered path gives a minimum 1-cycle latency from push to req.
- Grant:
  - grant = req && !stall.
  - When grant=1: cdb_valid=1 and cdb_tag/cdb_data = head entry in the same cycle; head increments at posedge.
  - When grant=0: cdb_valid=0, and cdb_tag/cdb_data hold the head entry (don't-care for consumers).
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Full with grant: the pop completes, in_ready stays 0 this cycle and rises the next cycle.
- Ordering: strictly FIFO; results are broadcast in acceptance order.
- stall_cycles increments at posedge when req && stall, and saturates at 2^CNT_W-1.
- Stall handling: a stalled request keeps req=1 and the same head entry until it is granted. The buffer never withdraws a request except on flush or reset.

Optional Feature:
- Macro: RESULT_BYPASS_EN.
- With the macro defined, when count==0, in_valid=1 and flush=0:
  - req=1 combinationally from in_valid.
  - If stall=0, the result is driven on cdb_* the same cycle and not written to the FIFO (zero latency).
  - If stall=1, the result is pushed normally.
- Without the macro, results always pass through the FIFO, with a minimum 1-cycle push-to-broadcast latency.

Test Plan:
- Reset then single result: rst high 2 cycles, then push tag=5 data=0x1234 with stall=0.
  - Without bypass: req=1 and cdb_valid=1 with tag 5 / 0x1234 exactly one cycle after the push; count returns to 0.
  - With bypass: the same broadcast occurs in the push cycle.
- Back-pressure fill: push 4 results (tags 1..4) with stall=1 held.
  - in_ready=0 after the 4th push; stall_cycles counts the stalled cycles.
  - Then release stall: tags 1,2,3,4 broadcast on 4 consecutive cycles; in_ready=1 one cycle after the first pop.
- Alternating stall, mirroring arbiter contention: stall toggles every 2 cycles while pushing tags 10..13.
  - Each tag is broadcast exactly once, in order.
  - cdb_valid never coincides with stall=1.
- Simultaneous push/pop at count=2: push tag 7 in the same cycle as a grant.
  - count stays 2; tag 7 is broadcast after the two older entries.
- Flush mid-stream: 3 entries buffered, flush=1 with in_valid=1 (tag 9).
  - The next cycle shows req=0 and count=0; tag 9 is never broadcast.
  - A push after the flush is broadcast normally.
- Saturation and reset mid-operation:
  - Hold req && stall for 300 cycles with CNT_W=8: stall_cycles=255.
  - Assert rst with entries buffered: all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/cdb_result_buffer.sv
// rtl/cdb_result_buffer.sv - result queue and requester endpoint for the result-bus arbiter
//
// Purpose: buffers completed results from one functional unit, requests the
// common data bus, honours the arbiter's stall, and broadcasts results in
// acceptance order. Back-pressures the unit through in_ready when full.
//
// Optional feature: define RESULT_BYPASS_EN to let a result arriving at an
// empty buffer go straight onto the bus in the same cycle when not stalled.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   flush              squash every buffered result
//   in_valid/in_tag/in_data/in_ready   result input from the functional unit
//   req / stall        request to arbiter and its same-cycle refusal
//   cdb_valid/cdb_tag/cdb_data         granted broadcast on the common data bus
//   stall_cycles       saturating count of cycles with req && stall
module cdb_result_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              req,
  input  logic              stall,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [TAG_W-1:0]  tag_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic [IDX_W-1:0]  head_idx;
  logic [IDX_W-1:0]  tail_idx;
  logic              nonempty;
  logic              bypass;
  logic              grant;
  logic              push;
  logic              pop;

  // Pointers carry one extra bit; only the low bits address storage, so they
  // wrap modulo DEPTH naturally.
  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  always_comb begin
    nonempty = (count_q != '0);
    // Based on registered count only, so stall never reaches in_ready.
    in_ready = (count_q < DEPTH_C);
`ifdef RESULT_BYPASS_EN
    bypass   = !nonempty && in_valid && !flush;
`else
    bypass   = 1'b0;
`endif
    req       = (nonempty || bypass) && !flush;
    grant     = req && !stall;
    cdb_valid = grant;
    // Outside a grant the bus carries the head entry (or bypassed input);
    // consumers ignore it because cdb_valid is low.
    cdb_tag   = bypass ? in_tag  : tag_q[head_idx];
    cdb_data  = bypass ? in_data : data_q[head_idx];
    stall_cycles = stall_cnt_q;

    // A granted bypass consumes the input directly; a stalled bypass falls
    // back to a normal push.
    pop  = grant && !bypass;
    push = in_valid && in_ready && !flush && !(bypass && grant);

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    tag_d   = tag_q;
    data_d  = data_q;

    if (flush) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) begin
        tag_d[tail_idx]  = in_tag;
        data_d[tail_idx] = in_data;
        tail_d           = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (req && stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_cdb_result_buffer.sv
// tb/tb_cdb_result_buffer.sv - scoreboard bench for cdb_result_buffer
module tb_cdb_result_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [5:0]  in_tag;
  logic [31:0] in_data;
  logic        in_ready;
  logic        req;
  logic        stall;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [7:0]  stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  cdb_result_buffer #(.DEPTH(4), .DATA_W(32), .TAG_W(6), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_tag       (in_tag),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .req          (req),
    .stall        (stall),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [5:0] t);
    return 32'hC0DE_0000 | {26'd0, t} * 32'd17;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a result this cycle; expect it on the bus only if it survives.
  task automatic drive(input logic [5:0] t, input logic [31:0] d, input bit expect_out);
    in_valid = 1'b1;
    in_tag   = t;
    in_data  = d;
    if (expect_out) exp_q.push_back('{tag: t, data: d});
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_tag   = '0;
    in_data  = '0;
  endtask

  // Monitor: every broadcast must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && cdb_valid) begin
      exp_t e;
      chk("cdb_valid_without_stall", stall, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_broadcast: got tag %0d, no result outstanding", cdb_tag);
      end else begin
        e = exp_q.pop_front();
        chk("cdb_tag", cdb_tag, e.tag);
        chk("cdb_data", cdb_data, e.data);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nt;
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    idle();
    step();
    step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cdb_tag", cdb_tag, 0);
    chk("rst_cdb_data", cdb_data, 0);
    chk("rst_stall_cycles", stall_cycles, 0);

    // Single result latency
    step();
    drive(6'd5, 32'h1234, 1);
    @(negedge clk);
`ifdef RESULT_BYPASS_EN
    chk("single_push_cycle_valid", cdb_valid, 1);
`else
    chk("single_push_cycle_valid", cdb_valid, 0);
    chk("single_push_cycle_req", req, 0);
`endif
    step();
    idle();
    @(negedge clk);
`ifdef RESULT_BYPASS_EN
    chk("single_next_req", req, 0);
`else
    chk("single_next_req", req, 1);
    chk("single_next_valid", cdb_valid, 1);
`endif
    step();
    @(negedge clk);
    chk("single_drained_req", req, 0);

    // Back-pressure fill
    step();
    stall = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      drive(t[5:0], data_of(t[5:0]), 1);
      step();
    end
    idle();
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_req", req, 1);
`ifdef RESULT_BYPASS_EN
    chk("full_stall_cycles", stall_cycles, 4);
`else
    chk("full_stall_cycles", stall_cycles, 3);
`endif
    step();
    stall = 1'b0;
    @(negedge clk);
    chk("first_pop_in_ready", in_ready, 0);
    step();
    @(negedge clk);
    chk("after_pop_in_ready", in_ready, 1);
    step();
    step();
    step();
    @(negedge clk);
    chk("fill_drained", exp_q.size(), 0);

    // Alternating stall contention
    nt = 10;
    for (int i = 0; i < 16; i++) begin
      stall = i[1];
      if (nt <= 13 && in_ready) begin
        drive(nt[5:0], data_of(nt[5:0]), 1);
        nt++;
      end else begin
        idle();
      end
      step();
    end
    idle();
    stall = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("alt_all_broadcast", exp_q.size(), 0);
    chk("alt_idle_req", req, 0);

    // Simultaneous push and pop at count=2
    step();
    stall = 1'b1;
    drive(6'd20, data_of(6'd20), 1);
    step();
    drive(6'd21, data_of(6'd21), 1);
    step();
    stall = 1'b0;
    drive(6'd7, data_of(6'd7), 1);
    @(negedge clk);
    chk("pushpop_grant", cdb_valid, 1);
    step();
    idle();
    step();
    step();
    @(negedge clk);
    chk("pushpop_count_two_drained", req, 0);
    chk("pushpop_order_done", exp_q.size(), 0);

    // Flush mid-stream
    step();
    stall = 1'b1;
    drive(6'd30, data_of(6'd30), 0);
    step();
    drive(6'd31, data_of(6'd31), 0);
    step();
    drive(6'd32, data_of(6'd32), 0);
    step();
    flush = 1'b1;
    drive(6'd9, data_of(6'd9), 0);
    @(negedge clk);
    chk("flush_cycle_req", req, 0);
    chk("flush_cycle_valid", cdb_valid, 0);
    step();
    flush = 1'b0;
    idle();
    @(negedge clk);
    chk("post_flush_req", req, 0);
    chk("post_flush_in_ready", in_ready, 1);
    step();
    stall = 1'b0;
    drive(6'd40, data_of(6'd40), 1);
    step();
    idle();
    step();
    step();
    @(negedge clk);
    chk("post_flush_broadcast", exp_q.size(), 0);

    // Saturation, then reset with entries buffered
    stall = 1'b1;
    drive(6'd50, data_of(6'd50), 0);
    step();
    drive(6'd51, data_of(6'd51), 0);
    step();
    idle();
    repeat (300) step();
    @(negedge clk);
    chk("sat_stall_cycles", stall_cycles, 255);
    chk("sat_req_held", req, 1);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("midrst_req", req, 0);
    chk("midrst_cdb_valid", cdb_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_cdb_tag", cdb_tag, 0);
    chk("midrst_cdb_data", cdb_data, 0);
    chk("midrst_stall_cycles", stall_cycles, 0);
    step();
    rst = 1'b0;
    stall = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
